// File: rtl/booth_mult_unit_pkg.sv
// rtl/booth_mult_unit_pkg.sv - shared state encodings and widths for the Booth multiplier
package booth_mult_unit_pkg;

    localparam int MULT_WIDTH = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Booth recoding of {q0, x}: the pair of multiplier bits examined each step
    typedef enum logic [1:0] {
        OP_NOP0 = 2'b00,
        OP_ADD  = 2'b01,
        OP_SUB  = 2'b10,
        OP_NOP1 = 2'b11
    } booth_op_t;

endpackage

// File: rtl/booth_mult_unit_reg.sv
// rtl/booth_mult_unit_reg.sv - enable register with asynchronous active-high clear
module dffe_ref #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/booth_mult_unit_step.sv
// rtl/booth_mult_unit_step.sv - one radix-2 Booth add/subtract plus arithmetic shift
module booth_step
    import booth_mult_unit_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
) (
    input  logic [2*WIDTH:0] prod,
    input  logic [WIDTH-1:0] m,
    output logic [2*WIDTH:0] next_prod
);

    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH:0]   hi_x;
    logic [WIDTH:0]   m_x;
    logic [WIDTH:0]   sum;

    assign hi   = prod[2*WIDTH:WIDTH+1];
    assign lo   = prod[WIDTH:1];
    assign hi_x = {hi[WIDTH-1], hi};
    assign m_x  = {m[WIDTH-1], m};

    always_comb begin
        sum = hi_x;
        case (booth_op_t'(prod[1:0]))
            OP_ADD:  sum = hi_x + m_x;
            OP_SUB:  sum = hi_x - m_x;
            default: sum = hi_x;
        endcase
    end

    // Shifting {sum, lo, x} right by one drops x and lands exactly on {sum, lo};
    // the extra sum bit carries the sign, so M = most-negative cannot overflow.
    assign next_prod = {sum, lo};

endmodule

// File: rtl/booth_mult_unit.sv
// rtl/booth_mult_unit.sv - sequential signed radix-2 Booth multiplier with overflow flag
module booth_mult_unit
    import booth_mult_unit_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             clr,
    input  logic             ctrl_MULT,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY
);

    localparam int PW = 2*WIDTH + 1;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] m_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             count_en;
    logic [PW-1:0]    prod_q;
    logic [PW-1:0]    prod_d;
    logic [PW-1:0]    prod_step;

    always_ff @(posedge clock or posedge clr) begin
        if (clr) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A start pulse overrides every other transition, including mid-run restarts
    always_comb begin
        state_nxt = state;
        prod_d    = prod_q;
        count_d   = count_q + 1'b1;
        count_en  = 1'b0;
        if (ctrl_MULT) begin
            state_nxt = S_RUN;
            prod_d    = {{WIDTH{1'b0}}, data_operandB, 1'b0};
            count_d   = '0;
            count_en  = 1'b1;
        end else begin
            case (state)
                S_RUN: begin
                    prod_d   = prod_step;
                    count_en = 1'b1;
                    if (count_q == CNT_W'(WIDTH-1)) begin
                        state_nxt = S_DONE;
                    end
                end
                S_DONE:  state_nxt = S_IDLE;
                default: state_nxt = state;
            endcase
        end
    end

    booth_step #(.WIDTH(WIDTH)) u_step (
        .prod      (prod_q),
        .m         (m_q),
        .next_prod (prod_step)
    );

    dffe_ref #(.W(WIDTH)) u_m (
        .clk (clock),
        .clr (clr),
        .en  (ctrl_MULT),
        .d   (data_operandA),
        .q   (m_q)
    );

    dffe_ref #(.W(CNT_W)) u_count (
        .clk (clock),
        .clr (clr),
        .en  (count_en),
        .d   (count_d),
        .q   (count_q)
    );

    dffe_ref #(.W(PW)) u_prod (
        .clk (clock),
        .clr (clr),
        .en  (1'b1),
        .d   (prod_d),
        .q   (prod_q)
    );

    assign data_result    = prod_q[WIDTH:1];
    assign data_exception = (prod_q[2*WIDTH:WIDTH+1] != {WIDTH{prod_q[WIDTH]}});
    assign data_resultRDY = (state == S_DONE);

endmodule

// File: tb/tb_booth_mult_unit.sv
// tb/tb_booth_mult_unit.sv - directed table-driven bench for booth_mult_unit
module tb_booth_mult_unit;

    logic        clock = 1'b0;
    logic        clr;
    logic        ctrl_MULT;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] result;
    logic        exc;
    logic        rdy;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        exc;
    } vec_t;

    vec_t vecs[10];

    booth_mult_unit dut (
        .clock          (clock),
        .clr            (clr),
        .ctrl_MULT      (ctrl_MULT),
        .data_operandA  (a),
        .data_operandB  (b),
        .data_result    (result),
        .data_exception (exc),
        .data_resultRDY (rdy)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Returns at the falling edge after the start edge, with operands scrambled
    task automatic start(input logic [31:0] va, input logic [31:0] vb);
        @(negedge clock);
        a = va;
        b = vb;
        ctrl_MULT = 1'b1;
        @(negedge clock);
        ctrl_MULT = 1'b0;
        a = $urandom;
        b = $urandom;
    endtask

    task automatic wait_rdy(input string name, input int exp_lat,
                            input logic [31:0] er, input logic ee);
        int k = 0;
        while (!rdy && k < 80) begin
            @(negedge clock);
            k++;
        end
        check({name, " latency"}, 32'(k), 32'(exp_lat));
        check({name, " result"}, result, er);
        check({name, " exception"}, 32'(exc), 32'(ee));
        @(negedge clock);
        check({name, " rdy one cycle"}, 32'(rdy), 32'd0);
        repeat (3) @(negedge clock);
        check({name, " result held"}, result, er);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;

        vecs[0] = '{"3x5",        32'd3,          32'd5,          32'd15,         1'b0};
        vecs[1] = '{"-7x6",       32'hFFFFFFF9,   32'd6,          32'hFFFFFFD6,   1'b0};
        vecs[2] = '{"-7x-6",      32'hFFFFFFF9,   32'hFFFFFFFA,   32'd42,         1'b0};
        vecs[3] = '{"min x min",  32'h80000000,   32'h80000000,   32'h00000000,   1'b1};
        vecs[4] = '{"max x 2",    32'h7FFFFFFF,   32'd2,          32'hFFFFFFFE,   1'b1};
        vecs[5] = '{"min x 1",    32'h80000000,   32'd1,          32'h80000000,   1'b0};
        vecs[6] = '{"2^16 sq",    32'h00010000,   32'h00010000,   32'h00000000,   1'b1};
        vecs[7] = '{"min x -1",   32'h80000000,   32'hFFFFFFFF,   32'h80000000,   1'b1};
        vecs[8] = '{"-1x-1",      32'hFFFFFFFF,   32'hFFFFFFFF,   32'd1,          1'b0};
        vecs[9] = '{"12345x-1",   32'd12345,      32'hFFFFFFFF,   32'hFFFFCFC7,   1'b0};

        clr = 1'b1;
        ctrl_MULT = 1'b0;
        a = 32'd0;
        b = 32'd0;
        #1;
        check("reset result", result, 32'd0);
        check("reset exception", 32'(exc), 32'd0);
        check("reset rdy", 32'(rdy), 32'd0);
        repeat (2) @(negedge clock);
        clr = 1'b0;

        for (int i = 0; i < 10; i++) begin
            start(vecs[i].a, vecs[i].b);
            wait_rdy(vecs[i].name, 32, vecs[i].res, vecs[i].exc);
        end

        // Restart mid-run: only the second multiply reports
        start(32'd2, 32'd3);
        seen = 1'b0;
        repeat (8) begin
            @(negedge clock);
            if (rdy) seen = 1'b1;
        end
        start(32'd4, 32'd5);
        check("restart no early rdy", 32'(seen), 32'd0);
        wait_rdy("restart", 32, 32'd20, 1'b0);

        // Clear mid-run aborts immediately and never reports
        start(32'd7, 32'd9);
        repeat (14) @(negedge clock);
        clr = 1'b1;
        #1;
        check("clr result", result, 32'd0);
        check("clr exception", 32'(exc), 32'd0);
        check("clr rdy", 32'(rdy), 32'd0);
        @(negedge clock);
        @(negedge clock);
        clr = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clock);
            if (rdy) seen = 1'b1;
        end
        check("clr no rdy", 32'(seen), 32'd0);
        start(32'd6, 32'd7);
        wait_rdy("after clr", 32, 32'd42, 1'b0);

        // Start held high keeps restarting; last start edge completes normally
        @(negedge clock);
        a = 32'd11;
        b = 32'd13;
        ctrl_MULT = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clock);
            if (rdy) seen = 1'b1;
        end
        check("held start no rdy", 32'(seen), 32'd0);
        ctrl_MULT = 1'b0;
        wait_rdy("held start", 32, 32'd143, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
